// File: rtl/hazard_pkg.sv
// Shared types and helpers for the pipeline stall/flush controller.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DMISS = 2'd1,
    LDUSE = 2'd2
  } haz_state_e;

  localparam int IDX_IFID = 0;
  localparam int IDX_IDEX = 1;
  localparam int IDX_EXMA = 2;
  localparam int IDX_MAWB = 3;

  localparam int MASK_W = 32;

  // Bits 0..k set; k < 0 yields an empty mask.
  function automatic logic [MASK_W-1:0] mask_upto(input int k);
    logic [MASK_W-1:0] m;
    m = '0;
    for (int i = 0; i < MASK_W; i++)
      if (i <= k) m[i] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/hazard_sat_counter.sv
// Saturating up-counter with enable, async active-low reset.
module hazard_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      cnt <= '0;
    else if (en && !(&cnt))
      cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush arbitration for the in-order pipeline registers.
// Optional macro HAZ_DMISS_EARLY_RESTART_EN releases upstream stages on a D-miss.
module pipe_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int NUM_REGS    = 4,
  parameter int DMISS_IDX   = IDX_EXMA,
  parameter int LU_IDX      = IDX_IDEX,
  parameter int LU_CYCLES   = 1,
  parameter int FLUSH_DEPTH = 2,
  parameter int CNT_W       = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_need_stall,
  input  logic                i_redirect,
  input  logic                i_icache_miss,
  input  logic                i_dcache_miss,
  output logic                o_pc_stall,
  output logic [NUM_REGS-1:0] o_stall,
  output logic [NUM_REGS-1:0] o_flush,
  output logic [1:0]          o_state,
  output logic                o_redirect_pend,
  output logic [CNT_W-1:0]    o_stall_cycles,
  output logic                o_pc_redirect
);

  localparam logic [NUM_REGS-1:0] DM_STALL =
    NUM_REGS'(mask_upto(DMISS_IDX));
  localparam logic [NUM_REGS-1:0] DM_FLUSH =
    NUM_REGS'(mask_upto(DMISS_IDX + 1) ^ mask_upto(DMISS_IDX));
  localparam logic [NUM_REGS-1:0] LU_STALL =
    NUM_REGS'(mask_upto(LU_IDX - 1));
  localparam logic [NUM_REGS-1:0] LU_FLUSH =
    NUM_REGS'(mask_upto(LU_IDX) ^ mask_upto(LU_IDX - 1));
  localparam logic [NUM_REGS-1:0] RD_FLUSH =
    NUM_REGS'(mask_upto(FLUSH_DEPTH - 1));
  localparam logic [2:0] LU_INIT = 3'(LU_CYCLES - 1);

  haz_state_e state, state_n;
  logic [2:0] lu_cnt, lu_n;
  logic       pend, pend_n;

  logic [NUM_REGS-1:0] stall_raw, flush_raw, flush_m;
  logic pc_stall, pc_redir;
  logic in_lu, redir;
  logic c_dm, c_rd, c_lu, c_ic;

  assign in_lu = (state == LDUSE);
  assign redir = i_redirect | pend;
  assign c_dm  = i_dcache_miss;
  assign c_rd  = !c_dm && redir;
  assign c_lu  = !c_dm && !redir && (in_lu || i_need_stall);
  assign c_ic  = !c_dm && !redir && !c_lu && i_icache_miss;

  always_comb begin
    stall_raw = '0;
    flush_raw = '0;
    pc_stall  = 1'b0;
    pc_redir  = 1'b0;
    state_n   = state;
    lu_n      = lu_cnt;
    pend_n    = pend;
    unique case (1'b1)
      c_dm: begin
`ifdef HAZ_DMISS_EARLY_RESTART_EN
        if (in_lu || i_need_stall) begin
          stall_raw = DM_STALL;
          pc_stall  = 1'b1;
        end else begin
          stall_raw = NUM_REGS'(1) << DMISS_IDX;
        end
`else
        stall_raw = DM_STALL;
        pc_stall  = 1'b1;
`endif
        flush_raw = DM_FLUSH;
        state_n   = DMISS;
        lu_n      = '0;
        pend_n    = pend | i_redirect;
      end
      c_rd: begin
        flush_raw = RD_FLUSH;
        pc_redir  = 1'b1;
        pend_n    = 1'b0;
        state_n   = RUN;
        lu_n      = '0;
      end
      c_lu: begin
        stall_raw = LU_STALL;
        flush_raw = LU_FLUSH;
        pc_stall  = 1'b1;
        if (in_lu) begin
          lu_n    = lu_cnt - 3'd1;
          state_n = (lu_cnt == 3'd1) ? RUN : LDUSE;
        end else if (LU_CYCLES > 1) begin
          lu_n    = LU_INIT;
          state_n = LDUSE;
        end else begin
          state_n = RUN;
        end
      end
      c_ic: begin
        flush_raw = NUM_REGS'(1);
        pc_stall  = 1'b1;
        state_n   = RUN;
      end
      default: state_n = RUN;
    endcase
  end

  // A flush loses to a hold on the next stage; a stall loses to a flush.
  assign flush_m = flush_raw & ~(stall_raw >> 1);

  assign o_flush         = rst ? flush_m : '0;
  assign o_stall         = rst ? (stall_raw & ~flush_m) : '0;
  assign o_pc_stall      = rst & pc_stall;
  assign o_pc_redirect   = rst & pc_redir;
  assign o_state         = state;
  assign o_redirect_pend = pend;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= RUN;
      lu_cnt <= '0;
      pend   <= 1'b0;
    end else begin
      state  <= state_n;
      lu_cnt <= lu_n;
      pend   <= pend_n;
    end
  end

  hazard_sat_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk (clk),
    .rst (rst),
    .en  (o_pc_stall),
    .cnt (o_stall_cycles)
  );

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Parametrised stall/flush controller for the in-order SoC pipeline; next generation of the hazard stall logic.
- Arbitrates load-use stalls, I-cache misses, D-cache misses and branch redirects into per-register stall/flush vectors for N pipeline registers.
- Adds sequential behaviour: multi-cycle load-use bubbles, redirects deferred across D-cache misses, and a saturating stall-cycle counter.
- Sits between the forward/branch units, the caches and the pipeline registers.

Parameters:
- NUM_REGS, 4: number of pipeline registers (index 0 = IF/ID, NUM_REGS-1 = MA/WB).
- DMISS_IDX, 2: register holding the missing memory op (EX/MA). Registers 0..DMISS_IDX are held; DMISS_IDX+1 is flushed.
- LU_IDX, 1: register that receives the load-use bubble (ID/EX).
- LU_CYCLES, 1: bubble cycles per load-use event (1..7).
- FLUSH_DEPTH, 2: registers 0..FLUSH_DEPTH-1 flushed on redirect (1..NUM_REGS).
- CNT_W, 16: stall counter width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous reset, active-low: asserted at 0, all state cleared immediately.
- i_need_stall  in  1  load-use hazard from the forward unit (level).
- i_redirect  in  1  branch mispredict / PC redirect, single-cycle pulse.
- i_icache_miss  in  1  held high until the fill completes.
- i_dcache_miss  in  1  held high until the fill completes.
- o_pc_stall  out  1  hold the PC.
- o_stall  out  NUM_REGS  per-register hold.
- o_flush  out  NUM_REGS  per-register bubble insert.
- o_state  out  2  FSM state: 0 RUN, 1 DMISS, 2 LDUSE.
- o_redirect_pend  out  1  a redirect is latched and deferred.
- o_stall_cycles  out  CNT_W  cycles with o_pc_stall=1, saturating.
- o_pc_redirect  out  1  tells the PC to take the redirect target this cycle.

Behaviour:
- Reset values: state RUN, lu_cnt=0, pend=0, o_stall_cycles=0, all outputs 0.
- All stall/flush/redirect outputs are combinational from current state and inputs: zero-cycle latency.
- A register is never both stalled and flushed. Flush wins on a conflict; the flush bit is masked by the stall of its downstream neighbour.
- Priority: dcache miss > redirect (or pending redirect) > load-use > icache miss.
- RUN, dcache miss:
  - o_pc_stall=1, o_stall[0..DMISS_IDX]=1, o_flush[DMISS_IDX+1]=1 (if it exists).
  - Next state DMISS.
  - If i_redirect is high the same cycle, set pend=1.
- DMISS:
  - Same outputs as the RUN dcache-miss case.
  - Any i_redirect sets pend.
  - When i_dcache_miss falls: next state RUN; outputs that cycle follow RUN rules with pend treated as i_redirect.
- Redirect (i_redirect | pend, no dcache miss):
  - o_flush[0..FLUSH_DEPTH-1]=1, o_pc_redirect=1, o_pc_stall=0.
  - pend cleared; any LDUSE sequence aborted (next state RUN, lu_cnt=0).
  - Overrides an icache miss; the wrong-path fetch is dropped.
- RUN, i_need_stall (no redirect):
  - o_pc_stall=1, o_stall[0..LU_IDX-1]=1, o_flush[LU_IDX]=1.
  - If LU_CYCLES>1: lu_cnt=LU_CYCLES-1, next state LDUSE.
- LDUSE:
  - Same outputs as the load-use case; lu_cnt decrements each cycle.
  - At lu_cnt==1 the next state is RUN.
  - A dcache miss in LDUSE: DMISS wins; remaining lu_cnt is discarded.
- RUN, icache miss only: o_pc_stall=1, o_flush[0]=1; downstream registers advance.
- o_stall_cycles increments when o_pc_stall=1 and the counter is not all-ones; it holds at 2^CNT_W-1.
- Reset asserted mid-DMISS or mid-LDUSE: immediate return to RUN with pend cleared.

Optional Feature:
- HAZ_DMISS_EARLY_RESTART_EN:
  - Defined: in DMISS, registers upstream of DMISS_IDX and the PC are released as soon as the dcache miss is seen, provided no load-use is pending. Only register DMISS_IDX is held and DMISS_IDX+1 is flushed.
  - Undefined: the full upstream hold described above.

Decomposition:
- Shared package hazard_pkg:
  - state enum (RUN/DMISS/LDUSE, 2-bit);
  - default register-index constants IDX_IFID=0, IDX_IDEX=1, IDX_EXMA=2, IDX_MAWB=3;
  - a function building the mask for "bits 0..k set" of width NUM_REGS.
- One natural sub-module: hazard_sat_counter, a parametrised CNT_W saturating incrementer with enable and the asynchronous active-low rst.

Test Plan:
- Reset: hold rst=0 with random inputs -> all outputs 0, o_state=0. Release, idle 5 cycles -> outputs stay 0.
- Load-use with LU_CYCLES=3: pulse i_need_stall one cycle -> o_pc_stall=1, o_stall=4'b0001, o_flush=4'b0010 for exactly 3 cycles; o_stall_cycles=3.
- Dcache miss for 10 cycles with a redirect pulse at cycle 4:
  - During the miss: o_stall=4'b0111, o_flush=4'b1000, o_redirect_pend=1 from cycle 5.
  - First cycle after the miss: o_flush=4'b0011, o_pc_redirect=1, pend=0.
- Redirect and icache miss together -> o_flush=4'b0011, o_pc_stall=0. Next cycle with the icache miss still high -> o_pc_stall=1, o_flush=4'b0001.
- Counter saturation with CNT_W=4: 20 stall cycles -> o_stall_cycles=15 and held.
- rst asserted during DMISS with pend=1 -> immediate RUN, pend=0, counter=0. After release, no stale redirect is issued.
